instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 22 ++
 rtl/instr_loader.sv | 106 ++++++++++
 tb/tb_instr_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream load port and instruction-memory write port of the instruction loader.
interface instr_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        load_error;

    modport slave (
        input  rx_data, rx_valid, reload,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_run, load_error
    );

    modport master (
        output rx_data, rx_valid, reload,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_run, load_error
    );
endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory, then releases the core.
// state  | meaning
// CNT_LO | waiting for word count low byte
// CNT_HI | waiting for word count high byte
// DATA   | assembling a 32-bit word from four bytes
// WRITE  | one-cycle memory write of the assembled word
// RUN    | load done, core released
// ERROR  | count exceeded capacity, core held
module instr_loader #(
    parameter int NUM_WORDS = 64
) (
    input  logic           clk,
    input  logic           rst,
    instr_loader_if.slave  bus
);
    localparam int WIDX_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, WRITE, RUN, ERROR} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_count;
    logic [WIDX_W-1:0]   r_word_idx;
    logic [1:0]          r_byte_idx;
    logic [31:0]         r_asm;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;

    logic                w_rx_ready;
    logic                w_accept;
    logic [15:0]         w_count_full;
    logic [WIDX_W-1:0]   w_word_next;

    assign w_accept     = bus.rx_valid && w_rx_ready;
    assign w_count_full = {bus.rx_data, r_count[7:0]};
    assign w_word_next  = r_word_idx + WIDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= CNT_LO;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_rx_ready = 1'b0;
        case (r_state)
            CNT_LO: begin
                w_rx_ready = 1'b1;
                if (w_accept) w_next = CNT_HI;
            end
            CNT_HI: begin
                w_rx_ready = 1'b1;
                if (w_accept) begin
                    if (w_count_full == 16'd0)              w_next = RUN;
                    else if (32'(w_count_full) > NUM_WORDS) w_next = ERROR;
                    else                                    w_next = DATA;
                end
            end
            DATA: begin
                w_rx_ready = 1'b1;
                if (w_accept && r_byte_idx == 2'd3) w_next = WRITE;
            end
            WRITE:      w_next = (16'(w_word_next) == r_count) ? RUN : DATA;
            RUN, ERROR: if (bus.reload) w_next = CNT_LO;
            default:    w_next = CNT_LO;
        endcase
    end

    // Address and data are captured with the last byte so they are valid during WRITE and hold afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                CNT_LO: if (w_accept) r_count[7:0] <= bus.rx_data;
                CNT_HI: if (w_accept) begin
                    r_count[15:8] <= bus.rx_data;
                    r_word_idx    <= '0;
                    r_byte_idx    <= '0;
                end
                DATA: if (w_accept) begin
                    r_asm[{r_byte_idx, 3'b000} +: 8] <= bus.rx_data;
                    r_byte_idx                       <= r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        r_addr  <= 32'(r_word_idx) << 2;
                        r_wdata <= {bus.rx_data, r_asm[23:0]};
                    end
                end
                WRITE:   r_word_idx <= w_word_next;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_we    = (r_state == WRITE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.core_run   = (r_state == RUN);
    assign bus.load_error = (r_state == ERROR);
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: load sequences, size limits, reload and async reset behaviour.
module tb_instr_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    instr_loader_if bus();

    instr_loader #(.NUM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Writes are logged at the falling edge; rx_ready must be low in every write cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            chk("ready_in_write", 32'(bus.rx_ready), 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  guard = 0;
        bit  acc = 1'b0;
        bit  acc_now;
        while (!acc && guard < 50) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'hxx;
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = b;
            end
            acc_now = bus.rx_valid && bus.rx_ready;
            step();
            acc = acc_now;
            guard++;
        end
        bus.rx_valid = 1'b0;
        chk("rx_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_seq(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        step();
        bus.reload = 1'b0;
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.reload   = 1'b0;

        step();
        chk("rst_we",    32'(bus.imem_we),    32'd0);
        chk("rst_addr",  bus.imem_addr,       32'd0);
        chk("rst_wdata", bus.imem_wdata,      32'd0);
        chk("rst_run",   32'(bus.core_run),   32'd0);
        chk("rst_err",   32'(bus.load_error), 32'd0);
        rst = 1'b1;
        step();
        chk("rst_ready", 32'(bus.rx_ready), 32'd1);

        // Two-word back-to-back load
        t0 = cyc;
        send_seq('{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00}, 1'b0);
        chk("b2b_cycles",   32'(cyc - t0),     32'd11);
        chk("w2_we",        32'(bus.imem_we),  32'd1);
        chk("w2_addr",      bus.imem_addr,     32'h4);
        chk("w2_wdata",     bus.imem_wdata,    32'h00200593);
        chk("w2_ready",     32'(bus.rx_ready), 32'd0);
        step();
        chk("l2_run",       32'(bus.core_run), 32'd1);
        chk("l2_we_off",    32'(bus.imem_we),  32'd0);
        chk("l2_addr_hold", bus.imem_addr,     32'h4);
        chk("l2_data_hold", bus.imem_wdata,    32'h00200593);
        chk("l2_nwr",       32'(wr_addr.size()), 32'd2);
        chk("l2_a0", qget(wr_addr, 0), 32'h0);
        chk("l2_d0", qget(wr_data, 0), 32'h00100513);
        chk("l2_a1", qget(wr_addr, 1), 32'h4);
        chk("l2_d1", qget(wr_data, 1), 32'h00200593);

        // RUN ignores pending bytes
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        repeat (10) step();
        chk("run_hold",  32'(bus.core_run), 32'd1);
        chk("run_ready", 32'(bus.rx_ready), 32'd0);
        chk("run_nwr",   32'(wr_addr.size()), 32'd2);
        bus.rx_valid = 1'b0;

        pulse_reload();
        chk("rl_run",   32'(bus.core_run), 32'd0);
        chk("rl_ready", 32'(bus.rx_ready), 32'd1);

        // Empty load
        wr_addr.delete();
        wr_data.delete();
        send_seq('{8'h00, 8'h00}, 1'b0);
        chk("empty_run", 32'(bus.core_run), 32'd1);
        chk("empty_nwr", 32'(wr_addr.size()), 32'd0);

        // Oversize load
        pulse_reload();
        send_seq('{8'h41, 8'h00}, 1'b0);
        chk("over_err",   32'(bus.load_error), 32'd1);
        chk("over_run",   32'(bus.core_run),   32'd0);
        chk("over_ready", 32'(bus.rx_ready),   32'd0);
        repeat (3) step();
        chk("over_stay",  32'(bus.load_error), 32'd1);
        pulse_reload();
        chk("over_rl_err",   32'(bus.load_error), 32'd0);
        chk("over_rl_ready", 32'(bus.rx_ready),   32'd1);

        // Three words with random valid gaps; reload held high throughout must be ignored
        bus.reload = 1'b1;
        send_seq('{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                   8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
        bus.reload = 1'b0;
        step();
        chk("g3_run", 32'(bus.core_run), 32'd1);
        chk("g3_nwr", 32'(wr_addr.size()), 32'd3);
        chk("g3_a0", qget(wr_addr, 0), 32'h0);
        chk("g3_d0", qget(wr_data, 0), 32'h11223344);
        chk("g3_a1", qget(wr_addr, 1), 32'h4);
        chk("g3_d1", qget(wr_data, 1), 32'hAABBCCDD);
        chk("g3_a2", qget(wr_addr, 2), 32'h8);
        chk("g3_d2", qget(wr_data, 2), 32'h01020304);

        // Count equal to capacity is accepted
        pulse_reload();
        send_seq('{8'h40, 8'h00}, 1'b0);
        chk("cap_err",   32'(bus.load_error), 32'd0);
        chk("cap_ready", 32'(bus.rx_ready),   32'd1);
        chk("cap_run",   32'(bus.core_run),   32'd0);

        // Reset acts between clock edges
        rst = 1'b0;
        #1;
        chk("async_addr",  bus.imem_addr,  32'd0);
        chk("async_wdata", bus.imem_wdata, 32'd0);
        step();
        rst = 1'b1;
        step();

        // Reset mid-load abandons the partial second word
        wr_addr.delete();
        wr_data.delete();
        send_seq('{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_we",    32'(bus.imem_we),    32'd0);
        chk("mid_addr",  bus.imem_addr,       32'd0);
        chk("mid_wdata", bus.imem_wdata,      32'd0);
        chk("mid_run",   32'(bus.core_run),   32'd0);
        chk("mid_err",   32'(bus.load_error), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("mid_ready", 32'(bus.rx_ready), 32'd1);
        chk("mid_nwr",   32'(wr_addr.size()), 32'd1);
        chk("mid_a0",    qget(wr_addr, 0), 32'h0);
        chk("mid_d0",    qget(wr_data, 0), 32'h44332211);

        send_seq('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0);
        chk("fresh_we",    32'(bus.imem_we), 32'd1);
        chk("fresh_addr",  bus.imem_addr,    32'h0);
        chk("fresh_wdata", bus.imem_wdata,   32'hDEADBEEF);
        step();
        chk("fresh_run", 32'(bus.core_run), 32'd1);
        chk("fresh_nwr", 32'(wr_addr.size()), 32'd2);
        chk("fresh_d1",  qget(wr_data, 1), 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
